apb_fp64_reader: RTL

APB requester that fetches one 64-bit IEEE-754 double from an APB completer as two 32-bit read transfers (high word, then low word) and presents the assembled value with its decoded fields. It is the reading end of the constant-store completer: where the bench currently drives PSEL by hand and picks up PRDATA1/PRDATA2, this block issues the reads itself and returns a checked, field-split result to the rest of the design.

---
 rtl/apb_fp64_reader_if.sv | 22 ++
 rtl/apb_fp64_reader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/apb_fp64_reader_if.sv
// APB3 requester/completer signal bundle used by the fp64 reader.
// The master modport is the requester side; the slave modport is the completer side.
interface apb_fp64_reader_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_fp64_reader.sv
// Fetches one IEEE-754 double as two APB reads (high word, then low word).
// It returns the assembled value split into sign, exponent, mantissa and class flags.
module apb_fp64_reader #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic                 i_start,
    input  logic [31:0]          i_req_addr,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output logic [63:0]          o_value,
    output logic                 o_sign,
    output logic [10:0]          o_exponent,
    output logic [51:0]          o_mantissa,
    output logic                 o_is_zero,
    output logic                 o_is_inf,
    output logic                 o_is_nan,
    apb_fp64_reader_if.master    apb
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP_HI  = 3'd1,
        ST_ACCESS_HI = 3'd2,
        ST_SETUP_LO  = 3'd3,
        ST_ACCESS_LO = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    state_t        r_state;
    logic          r_psel;
    logic          r_penable;
    logic [31:0]   r_paddr;
    logic [31:0]   r_hi;
    logic [63:0]   r_value;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [CW-1:0] r_wait_cnt;
    logic [2:0]    w_class;
    logic          w_unused_addr_lsbs;

    // Returns {is_zero, is_inf, is_nan}; subnormals and normals give all zeros.
    function automatic logic [2:0] fp64_class(input logic [63:0] v);
        logic exp_ones;
        logic exp_zero;
        logic man_zero;
        exp_ones = &v[62:52];
        exp_zero = ~|v[62:52];
        man_zero = ~|v[51:0];
        return {exp_zero & man_zero, exp_ones & man_zero, exp_ones & ~man_zero};
    endfunction

    // Request sequencer: drives the APB phases and all status outputs from registers.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state    <= ST_IDLE;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_paddr    <= 32'h0000_0000;
            r_hi       <= 32'h0000_0000;
            r_value    <= 64'h0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_paddr    <= {i_req_addr[31:2], 2'b00};
                        r_psel     <= 1'b1;
                        r_penable  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_err      <= 1'b0;
                        r_wait_cnt <= '0;
                        r_state    <= ST_SETUP_HI;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SETUP_HI: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS_HI;
                end
                ST_ACCESS_HI: begin
                    if (apb.PREADY) begin
                        if (apb.PSLVERR) begin
                            r_psel    <= 1'b0;
                            r_penable <= 1'b0;
                            r_done    <= 1'b1;
                            r_err     <= 1'b1;
                            r_state   <= ST_DONE;
                        end else begin
                            // PSEL stays high: the low-word setup follows with no idle gap.
                            r_hi       <= apb.PRDATA;
                            r_penable  <= 1'b0;
                            r_paddr    <= r_paddr + 32'd4;
                            r_wait_cnt <= '0;
                            r_state    <= ST_SETUP_LO;
                        end
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                ST_SETUP_LO: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS_LO;
                end
                ST_ACCESS_LO: begin
                    if (apb.PREADY) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= ST_DONE;
                        if (apb.PSLVERR) begin
                            r_err <= 1'b1;
                        end else begin
                            r_err   <= 1'b0;
                            r_value <= {r_hi, apb.PRDATA};
                        end
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_busy    <= 1'b0;
                    r_err     <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_class            = fp64_class(r_value);
    assign w_unused_addr_lsbs = ^i_req_addr[1:0];

    assign apb.PSEL    = r_psel;
    assign apb.PENABLE = r_penable;
    assign apb.PADDR   = r_paddr;
    assign apb.PWRITE  = 1'b0;
    assign apb.PWDATA  = 32'h0000_0000;

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_value    = r_value;
    assign o_sign     = r_value[63];
    assign o_exponent = r_value[62:52];
    assign o_mantissa = r_value[51:0];
    assign o_is_zero  = w_class[2];
    assign o_is_inf   = w_class[1];
    assign o_is_nan   = w_class[0];

endmodule
